// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} dmem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes touched by an access; halfwords look at addr[1] only.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B, F3_BU: byte_en = 4'b0001 << a;
      F3_H, F3_HU: byte_en = a[1] ? 4'b1100 : 4'b0011;
      F3_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline (master) and the data memory (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a RAM word and sign/zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0]     word_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] rdata_o
);
  logic [7:0]  b;
  logic [15:0] h;

  // Lane select, then extension by width code; unknown codes read as 0.
  always_comb begin
    case (addr_i)
      2'd0:    b = word_i[7:0];
      2'd1:    b = word_i[15:8];
      2'd2:    b = word_i[23:16];
      default: b = word_i[31:24];
    endcase
    h = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_B:    rdata_o = {{24{b[7]}}, b};
      F3_BU:   rdata_o = {24'd0, b};
      F3_H:    rdata_o = {{16{h[15]}}, h};
      F3_HU:   rdata_o = {16'd0, h};
      F3_W:    rdata_o = word_i;
      default: rdata_o = '0;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// one-cycle response pulse. Define DMEM_MISALIGN_TRAP_EN to flag misaligned
// half/word accesses as errors instead of silently aligning them.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam logic [3:0] WAIT_LD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [DEPTH_LOG2+1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0]       rsp_rdata_q;
  logic [31:0]           mem [2**DEPTH_LOG2];

  logic                  accept, illegal, misalign, err;
  logic [3:0]            be;
  logic [31:0]           wr_word, rd_word;
  logic [XLEN-1:0]       ld_data;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  unused_addr_hi;

  assign accept         = bus.req_valid && (state_q == IDLE);
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  // High address bits fall outside the RAM; the address simply wraps.
  assign unused_addr_hi = ^bus.req_addr[XLEN-1:DEPTH_LOG2+2];
  assign idx            = addr_q[DEPTH_LOG2+1:2];
  assign rd_word        = mem[idx];

  // Next state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) state_d = ACCESS;
        else begin
          state_d = WAIT;
          cnt_d   = WAIT_LD;
        end
      end
      WAIT:    if (cnt_q == 4'd0) state_d = ACCESS;
               else cnt_d = cnt_q - 4'd1;
      ACCESS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode of the captured request: legality, lanes, replicated store data.
  always_comb begin
    illegal  = !(f3_q inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
               (we_q && (f3_q inside {F3_BU, F3_HU}));
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((f3_q == F3_H || f3_q == F3_HU) && addr_q[0]) ||
               ((f3_q == F3_W) && (addr_q[1:0] != 2'b00));
`endif
    err = illegal || misalign;
    be  = byte_en(f3_q, addr_q[1:0]);
    case (f3_q[1:0])
      2'b00:   wr_word = {4{wdata_q[7:0]}};
      2'b01:   wr_word = {2{wdata_q[15:0]}};
      default: wr_word = wdata_q;
    endcase
  end

  dmem_load_align u_align (
    .word_i   (rd_word),
    .addr_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .rdata_o  (ld_data)
  );

  // FSM state and response registers; response is produced as ACCESS ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= (state_q == ACCESS);
      if (state_q == ACCESS) begin
        rsp_rdata_q <= (err || we_q) ? '0 : ld_data;
        rsp_err_q   <= err;
      end
    end
  end

  // Request capture on accept; inputs are ignored while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      f3_q    <= bus.req_funct3;
      addr_q  <= bus.req_addr[DEPTH_LOG2+1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  // Byte-enable store; a reset on the committing edge drops the write.
  always_ff @(posedge clk) begin
    if (rst && (state_q == ACCESS) && we_q && !err) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-built multi-cycle
// sequences (held valid, reset mid-operation) and random traffic against a
// byte-array reference model.
module tb_dmem_responder;
  localparam int W          = 1;
  localparam int DL         = 10;
  localparam int MEM_BYTES  = 4 * (2**DL);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  dmem_responder_if bus();

  dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] mem_m [MEM_BYTES];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rd = rd; v.exp_err = er;
    vt.push_back(v);
  endfunction

  // Reference: byte-addressed memory, size from width code, natural alignment.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int sz; bit sgn; bit ok; int b; longint v;
    sz = 0; sgn = 1'b0;
    case (f3)
      3'd0: begin sz = 1; sgn = 1'b1; end
      3'd1: begin sz = 2; sgn = 1'b1; end
      3'd2: sz = 4;
      3'd4: sz = 1;
      3'd5: sz = 2;
      default: sz = 0;
    endcase
    ok = (sz != 0) && !(we && f3[2]);
    b  = int'(a % MEM_BYTES);
    if (TRAP && ok && ((b % sz) != 0)) ok = 1'b0;
    rd = '0;
    er = !ok;
    if (ok) begin
      b = b - (b % sz);
      if (we) begin
        for (int i = 0; i < sz; i++) mem_m[b+i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < sz; i++) v += longint'(mem_m[b+i]) << (8*i);
        if (sgn && v >= (longint'(1) << (8*sz-1))) v -= longint'(1) << (8*sz);
        rd = v[31:0];
      end
    end
  endfunction

  // One transaction; entered and left at a negedge. lat = cycles from accept edge to pulse.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.req_ready) chk("ready_wait", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rd = '0; er = 1'b0; lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rd = bus.rsp_rdata; er = bus.rsp_err; lat = k - 1;
        break;
      end
    end
    @(negedge clk);
    chk("rsp_pulse_width", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  logic [31:0] rd, exp_rd, w13;
  logic        er, exp_er;
  int          lat, pulses;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = '0; bus.req_wdata = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

    // Directed table: we, f3, addr, wdata, expected rdata, expected err.
    w13 = TRAP ? 32'h800180EF : 32'h80011234;
    add(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    add(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    add(1, 3'b000, 32'h11, 32'h80, 32'h0, 0);
    add(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 0);
    add(0, 3'b100, 32'h11, 32'h0, 32'h00000080, 0);
    add(0, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 0);
    add(1, 3'b001, 32'h12, 32'h8001, 32'h0, 0);
    add(0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 0);
    add(0, 3'b101, 32'h12, 32'h0, 32'h00008001, 0);
    add(0, 3'b010, 32'h10, 32'h0, 32'h800180EF, 0);
    add(0, 3'b010, 32'h13, 32'h0, TRAP ? 32'h0 : 32'h800180EF, TRAP);
    add(1, 3'b001, 32'h11, 32'h1234, 32'h0, TRAP);
    add(0, 3'b010, 32'h10, 32'h0, w13, 0);
    add(0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    add(1, 3'b100, 32'h10, 32'h55, 32'h0, 1);
    add(0, 3'b010, 32'h10, 32'h0, w13, 0);
    add(1, 3'b010, 32'h20, 32'h11111111, 32'h0, 0);
    add(1, 3'b010, 32'h1024, 32'hCAFEF00D, 32'h0, 0);
    add(0, 3'b010, 32'h24, 32'h0, 32'hCAFEF00D, 0);
    add(0, 3'b000, 32'hFFFF_F027, 32'h0, 32'hFFFFFFCA, 0);

    foreach (vt[i]) begin
      txn(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(W + 1));
    end

    // req_valid held high: busy cycles refuse, exactly two back-to-back accepts.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h10;
    @(posedge clk);
    pulses = 0;
    for (int n = 1; n <= 2*(W+2); n++) begin
      @(negedge clk);
      if (n <= W + 1) chk($sformatf("hold_ready_n%0d", n), {31'd0, bus.req_ready}, 32'd0);
      if (bus.rsp_valid) begin
        pulses++;
        chk("hold_rdata", bus.rsp_rdata, w13);
      end
    end
    bus.req_valid = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd2);
    @(negedge clk);

    // Reset during WAIT of a store: no response, no write.
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rsp_valid_in_reset", {31'd0, bus.rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_after_release", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_rsp_valid_after", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_late_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    txn(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    chk("abort_old_value", rd, 32'h11111111);

    // Random traffic in a 64-byte window, random high address bits for wrap.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] wd;
      wd = $urandom;
      model(1'b1, 3'b010, 32'h100 + 32'(4*i), wd, exp_rd, exp_er);
      txn(1'b1, 3'b010, 32'h100 + 32'(4*i), wd, rd, er, lat);
      chk("init_err", {31'd0, er}, {31'd0, exp_er});
    end
    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, wd;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'($urandom_range(0, 63)));
      wd = $urandom;
      model(we, f3, a, wd, exp_rd, exp_er);
      txn(we, f3, a, wd, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, exp_er});
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(W + 1));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
